// File: rtl/alu_arbiter_16bit_pkg.sv
// Shared types and constants for the 16-bit add/sub math-unit arbiter.
package alu_arbiter_16bit_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_16bit_if.sv
// Request, math-unit and response signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface alu_arbiter_16bit_if #(
  parameter int NUM_REQ = 4
);
  import alu_arbiter_16bit_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]        req_sub;

  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic                      alu_sub;
  logic [DATA_W-1:0]         alu_sum;
  logic                      alu_cout;
  logic                      alu_overflow;
  logic                      alu_neg;
  logic                      alu_zero;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_sum;
  logic                      rsp_cout;
  logic                      rsp_overflow;
  logic                      rsp_neg;
  logic                      rsp_zero;

  logic                      busy;

  modport slave (
    input  req_valid, req_a, req_b, req_sub,
    input  alu_sum, alu_cout, alu_overflow, alu_neg, alu_zero,
    input  rsp_ready,
    output req_ready,
    output alu_a, alu_b, alu_sub,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow, rsp_neg, rsp_zero,
    output busy
  );

  modport master (
    output req_valid, req_a, req_b, req_sub,
    output alu_sum, alu_cout, alu_overflow, alu_neg, alu_zero,
    output rsp_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_sub,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow, rsp_neg, rsp_zero,
    input  busy
  );

endinterface

// File: rtl/alu_arbiter_16bit_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping to 0.
module alu_arbiter_16bit_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      j = int'(ptr) + off;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter_16bit.sv
// Shares one combinational add/sub unit between NUM_REQ requesters.
// One operation in flight: IDLE (grant) -> EXEC (unit evaluates) -> HOLD (response).
module alu_arbiter_16bit #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  alu_arbiter_16bit_if.slave  bus
);
  import alu_arbiter_16bit_pkg::*;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic                accept;

  logic [DATA_W-1:0]   op_a_p0;
  logic [DATA_W-1:0]   op_b_p0;
  logic                op_sub_p0;
  logic [ID_W-1:0]     op_id_p0;

  logic                rsp_valid_p1;
  logic [ID_W-1:0]     rsp_id_p1;
  logic [DATA_W-1:0]   rsp_sum_p1;
  logic                rsp_cout_p1;
  logic                rsp_overflow_p1;
  logic                rsp_neg_p1;
  logic                rsp_zero_p1;

  logic [NUM_REQ-1:0]  req_ready_c;
  logic                busy_c;

  alu_arbiter_16bit_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign accept = (state == ST_IDLE) && pick_any;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: one grant per IDLE cycle, single-cycle EXEC, HOLD until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_any)      state_nxt = ST_EXEC;
      ST_EXEC:                    state_nxt = ST_HOLD;
      ST_HOLD: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: grant is only visible in IDLE, busy everywhere else.
  always_comb begin
    req_ready_c = '0;
    busy_c      = 1'b1;
    if (state == ST_IDLE) begin
      req_ready_c = pick_grant;
      busy_c      = 1'b0;
    end
  end

  // Stage 0: latch the granted operands and advance the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_p0   <= '0;
      op_b_p0   <= '0;
      op_sub_p0 <= 1'b0;
      op_id_p0  <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      op_a_p0   <= bus.req_a[int'(pick_idx)*DATA_W +: DATA_W];
      op_b_p0   <= bus.req_b[int'(pick_idx)*DATA_W +: DATA_W];
      op_sub_p0 <= bus.req_sub[pick_idx];
      op_id_p0  <= pick_idx;
      rr_ptr    <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // Stage 1: capture the unit's result at the end of EXEC, release on consumer accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_p1    <= 1'b0;
      rsp_id_p1       <= '0;
      rsp_sum_p1      <= '0;
      rsp_cout_p1     <= 1'b0;
      rsp_overflow_p1 <= 1'b0;
      rsp_neg_p1      <= 1'b0;
      rsp_zero_p1     <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_valid_p1    <= 1'b1;
      rsp_id_p1       <= op_id_p0;
      rsp_sum_p1      <= bus.alu_sum;
      rsp_cout_p1     <= bus.alu_cout;
      rsp_overflow_p1 <= bus.alu_overflow;
      rsp_neg_p1      <= bus.alu_neg;
      rsp_zero_p1     <= bus.alu_zero;
    end else if ((state == ST_HOLD) && bus.rsp_ready) begin
      rsp_valid_p1    <= 1'b0;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.busy         = busy_c;
  assign bus.alu_a        = op_a_p0;
  assign bus.alu_b        = op_b_p0;
  assign bus.alu_sub      = op_sub_p0;
  assign bus.rsp_valid    = rsp_valid_p1;
  assign bus.rsp_id       = rsp_id_p1;
  assign bus.rsp_sum      = rsp_sum_p1;
  assign bus.rsp_cout     = rsp_cout_p1;
  assign bus.rsp_overflow = rsp_overflow_p1;
  assign bus.rsp_neg      = rsp_neg_p1;
  assign bus.rsp_zero     = rsp_zero_p1;

endmodule

// File: tb/tb_alu_arbiter_16bit.sv
// Bench for alu_arbiter_16bit: models the external add/sub unit and checks
// grants, latency, handshakes and results against an arithmetic reference.
module tb_alu_arbiter_16bit;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_16bit_if #(.NUM_REQ(N)) bus ();

  alu_arbiter_16bit #(.NUM_REQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External math unit: two's-complement add, or add of inverted B plus one.
  logic [16:0] mu_t;
  logic [15:0] mu_b;
  always_comb begin
    mu_b             = bus.alu_sub ? ~bus.alu_b : bus.alu_b;
    mu_t             = {1'b0, bus.alu_a} + {1'b0, mu_b} + {16'd0, bus.alu_sub};
    bus.alu_sum      = mu_t[15:0];
    bus.alu_cout     = mu_t[16];
    bus.alu_overflow = (bus.alu_a[15] == mu_b[15]) && (mu_t[15] != bus.alu_a[15]);
    bus.alu_neg      = mu_t[15];
    bus.alu_zero     = (mu_t[15:0] == 16'd0);
  end

  int errors = 0;
  int checks = 0;

  logic [N-1:0]       vld;
  logic [N-1:0]       sub_v;
  logic [N-1:0][15:0] a_v;
  logic [N-1:0][15:0] b_v;
  logic               rdy;
  int                 mrr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req_valid = vld;
    bus.req_a     = a_v;
    bus.req_b     = b_v;
    bus.req_sub   = sub_v;
    bus.rsp_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: nearest valid requester at or after the pointer.
  function automatic int model_pick();
    for (int off = 0; off < N; off++) begin
      if (vld[(mrr + off) % N]) return (mrr + off) % N;
    end
    return -1;
  endfunction

  // Arithmetic reference packed as {id, cout, overflow, neg, zero, sum}.
  function automatic logic [31:0] ref_result(input int id, input logic [15:0] a,
                                             input logic [15:0] b, input bit s);
    int ua, ub, sa, sb, r, sr;
    bit c, v;
    logic [15:0] sum;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      r  = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      r  = ua + ub;
      sr = sa + sb;
      c  = (r > 65535);
    end
    v   = (sr > 32767) || (sr < -32768);
    sum = r[15:0];
    return {12'(id), c, v, sum[15], (sum == 16'h0000), sum};
  endfunction

  function automatic logic [31:0] obs_pack();
    return {12'(bus.rsp_id), bus.rsp_cout, bus.rsp_overflow, bus.rsp_neg, bus.rsp_zero, bus.rsp_sum};
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_rsp"},       64'(obs_pack()), 64'd0);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_busy"},      64'(bus.busy), 64'd0);
    check({tag, "_alu"},       64'({bus.alu_a, bus.alu_b, bus.alu_sub}), 64'd0);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check_cleared(tag);
    @(negedge clk);
    reset = 1'b0;
    mrr   = 0;
    tick();
  endtask

  // One full transaction from grant to response consumption.
  // keep: the granted port immediately presents a new random op.
  // hold: number of HOLD cycles with rsp_ready low.
  task automatic txn(input bit keep, input int hold);
    int g;
    logic [31:0] e;
    logic [15:0] ea, eb;
    bit es;
    if (vld == '0) vld[0] = 1'b1;
    rdy = (hold == 0);
    apply();
    #1;
    check("idle_busy", 64'(bus.busy), 64'd0);
    g = model_pick();
    check("grant", 64'(bus.req_ready), 64'(1) << g);
    ea  = a_v[g];
    eb  = b_v[g];
    es  = sub_v[g];
    e   = ref_result(g, ea, eb, es);
    mrr = (g + 1) % N;
    tick();
    if (keep) begin
      a_v[g]   = 16'($urandom);
      b_v[g]   = 16'($urandom);
      sub_v[g] = 1'($urandom);
    end else begin
      vld[g] = 1'b0;
    end
    apply();
    #1;
    check("exec_ready",     64'(bus.req_ready), 64'd0);
    check("exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("exec_busy",      64'(bus.busy), 64'd1);
    check("exec_alu_ops",   64'({bus.alu_a, bus.alu_b, bus.alu_sub}), 64'({ea, eb, es}));
    tick();
    #1;
    check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("rsp_data",  64'(obs_pack()), 64'(e));
    for (int k = 0; k < hold; k++) begin
      tick();
      #1;
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_data",  64'(obs_pack()), 64'(e));
      check("hold_ready", 64'(bus.req_ready), 64'd0);
      check("hold_busy",  64'(bus.busy), 64'd1);
    end
    rdy = 1'b1;
    apply();
    tick();
    #1;
    check("done_valid", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] dir_a [3] = '{16'h0003, 16'h0005, 16'h7FFF};
  logic [15:0] dir_b [3] = '{16'h0005, 16'h0005, 16'h0001};
  bit          dir_s [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    reset = 1'b1;
    vld   = '0;
    sub_v = '0;
    a_v   = '0;
    b_v   = '0;
    rdy   = 1'b1;
    mrr   = 0;
    apply();
    repeat (2) @(posedge clk);
    #1;
    check_cleared("por");
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    check("idle_no_grant", 64'(bus.req_ready), 64'd0);
    check("idle_no_busy",  64'(bus.busy), 64'd0);

    // Reset while idle, then a lone request on the highest port.
    pulse_reset("idle_rst");
    vld = 4'b1000; a_v[3] = 16'h1234; b_v[3] = 16'h0001; sub_v[3] = 1'b0;
    txn(1'b0, 0);

    // Simple add on port 1.
    vld = 4'b0010; a_v[1] = 16'h0005; b_v[1] = 16'h0003; sub_v[1] = 1'b0;
    txn(1'b0, 0);

    // Flag corner cases on port 0: negative, zero with carry, signed overflow.
    for (int i = 0; i < 3; i++) begin
      vld = 4'b0001; a_v[0] = dir_a[i]; b_v[0] = dir_b[i]; sub_v[0] = dir_s[i];
      txn(1'b0, 0);
    end

    // All ports requesting continuously: rotation 0,1,2,3,0,1 at one accept per 3 cycles.
    pulse_reset("rr_rst");
    for (int p = 0; p < N; p++) begin
      a_v[p] = 16'($urandom); b_v[p] = 16'($urandom); sub_v[p] = 1'($urandom);
    end
    vld = 4'b1111;
    for (int i = 0; i < 6; i++) txn(1'b1, 0);

    // Consumer stalls for 5 HOLD cycles.
    vld = 4'b0100; a_v[2] = 16'hABCD; b_v[2] = 16'h1111; sub_v[2] = 1'b1;
    txn(1'b0, 5);

    // Reset during EXEC discards the op; pointer returns to 0.
    vld = 4'b0001; a_v[0] = 16'h00FF; b_v[0] = 16'h0001; sub_v[0] = 1'b0;
    apply();
    tick();
    check("exec_entry_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    vld   = '0;
    apply();
    #1;
    check_cleared("exec_rst");
    @(negedge clk);
    reset = 1'b0;
    mrr   = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("discarded_no_rsp", 64'({bus.rsp_valid, bus.busy}), 64'd0);
    end
    vld = 4'b1100;
    a_v[2] = 16'h0010; b_v[2] = 16'h0020; sub_v[2] = 1'b0;
    a_v[3] = 16'h0030; b_v[3] = 16'h0040; sub_v[3] = 1'b1;
    txn(1'b0, 0);

    // Randomized traffic: ports join and drop out, stalls vary.
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < N; p++) begin
        if (!vld[p]) begin
          if ($urandom_range(0, 1) == 1) begin
            vld[p]   = 1'b1;
            a_v[p]   = 16'($urandom);
            b_v[p]   = 16'($urandom);
            sub_v[p] = 1'($urandom);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          vld[p] = 1'b0;
        end
      end
      txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
